// File: rtl/calc_pkg.sv
// Shared types and constants for the BCD calculator entry core.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] MINUS_CODE = 4'hE;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;

  localparam int unsigned DIGITS_MIN = 2;
  localparam int unsigned DIGITS_MAX = 8;

endpackage

// File: rtl/bcd_digit_alu.sv
// Single BCD digit adder/subtractor: d = a + b + cin or a - b - cin, mod 10.
module bcd_digit_alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] d,
  output logic       cout
);

  logic [4:0] sum5;
  logic [4:0] dif5;

  assign sum5 = 5'(a) + 5'(b) + 5'(cin);
  assign dif5 = 5'(a) - 5'(b) - 5'(cin);

  always_comb begin
    d    = 4'd0;
    cout = 1'b0;
    if (sub) begin
      // dif5[4] is the sign of the 5-bit difference: a borrow out
      cout = dif5[4];
      d    = dif5[4] ? 4'(dif5 + 5'd10) : dif5[3:0];
    end else begin
      cout = (sum5 > 5'd9);
      d    = (sum5 > 5'd9) ? 4'(sum5 - 5'd10) : sum5[3:0];
    end
  end

endmodule

// File: rtl/calc_entry_core.sv
// Digit-serial BCD calculator: operand entry, add/subtract, result display.
// Optional LEADING_BLANK_EN: blank leading zeros and show a minus sign.
module calc_entry_core
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned OPT_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            num,
  input  logic                  num_pressed,
  input  logic [OPT_W-1:0]      opt,
  input  logic                  opt_pressed,
  input  logic                  submit,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  neg,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_digits_range
    $error("calc_entry_core: DIGITS out of range");
  end

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]   a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            op_q, op_d, carry_q, carry_d, pass2_q, pass2_d;
  logic            neg_d, ovf_d;
  logic [W-1:0]    disp_d;
  logic            busy_d, done_d;

  // Strobe decode with submit > opt_pressed > num_pressed priority
  logic dig_ev, op_ev, eq_ev, op_valid, op_sel, result_ok, last;
  assign op_valid  = (opt == OPT_W'(OP_ADD)) || (opt == OPT_W'(OP_SUB));
  assign op_sel    = (opt == OPT_W'(OP_SUB));
  assign eq_ev     = submit;
  assign op_ev     = opt_pressed && !submit && op_valid;
  assign dig_ev    = num_pressed && !submit && !opt_pressed && (num <= MAX_DIGIT);
  assign result_ok = !neg && !overflow;
  assign last      = (idx_q == IDX_LAST);

  // Shared digit ALU: pass 2 computes 0 - R to recover the magnitude
  logic [3:0] alu_a, alu_b, alu_d;
  logic       alu_sub, alu_cout;
  assign alu_a   = pass2_q ? 4'd0 : a_q[{idx_q, 2'b00} +: 4];
  assign alu_b   = pass2_q ? res_q[{idx_q, 2'b00} +: 4] : b_q[{idx_q, 2'b00} +: 4];
  assign alu_sub = pass2_q | op_q;

  bcd_digit_alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .cin  (carry_q),
    .sub  (alu_sub),
    .d    (alu_d),
    .cout (alu_cout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ENTER_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ENTER_A: if (op_ev) state_d = ENTER_B;
      ENTER_B: if (eq_ev) state_d = CALC;
      CALC:    if (last && (pass2_q || !op_q || !alu_cout)) state_d = SHOW;
      SHOW: begin
        if (dig_ev)                      state_d = ENTER_A;
        else if (op_ev && result_ok)     state_d = ENTER_B;
        else if (eq_ev && result_ok)     state_d = CALC;
      end
      default: state_d = ENTER_A;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    idx_d   = idx_q;
    op_d    = op_q;
    carry_d = carry_q;
    pass2_d = pass2_q;
    neg_d   = neg;
    ovf_d   = overflow;
    case (state_q)
      ENTER_A: begin
        if (dig_ev) begin
          if (a_cnt_q < CNT_FULL) begin
            a_d     = {a_q[W-5:0], num};
            a_cnt_d = a_cnt_q + CW'(1);
          end
        end else if (op_ev) begin
          op_d    = op_sel;
          b_d     = '0;
          b_cnt_d = '0;
        end
      end
      ENTER_B: begin
        if (eq_ev) begin
          idx_d   = '0;
          carry_d = 1'b0;
          pass2_d = 1'b0;
          res_d   = '0;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
        end else if (op_ev) begin
          op_d = op_sel;
        end else if (dig_ev && (b_cnt_q < CNT_FULL)) begin
          b_d     = {b_q[W-5:0], num};
          b_cnt_d = b_cnt_q + CW'(1);
        end
      end
      CALC: begin
        res_d[{idx_q, 2'b00} +: 4] = alu_d;
        carry_d = alu_cout;
        idx_d   = idx_q + IW'(1);
        if (last) begin
          idx_d   = '0;
          carry_d = 1'b0;
          if (pass2_q) begin
            pass2_d = 1'b0;
            neg_d   = 1'b1;
          end else if (op_q) begin
            pass2_d = alu_cout;
          end else begin
            ovf_d = alu_cout;
          end
        end
      end
      SHOW: begin
        if (dig_ev) begin
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          a_d     = W'(num);
          a_cnt_d = CW'(1);
        end else if (op_ev && result_ok) begin
          a_d     = res_q;
          a_cnt_d = CNT_FULL;
          op_d    = op_sel;
          b_d     = '0;
          b_cnt_d = '0;
        end else if (eq_ev && result_ok) begin
          a_d     = res_q;
          a_cnt_d = CNT_FULL;
          idx_d   = '0;
          carry_d = 1'b0;
          pass2_d = 1'b0;
          res_d   = '0;
        end
      end
      default: ;
    endcase
  end

`ifdef LEADING_BLANK_EN
  function automatic logic [W-1:0] blank_lead(input logic [W-1:0] raw, input logic minus);
    logic [W-1:0] r;
    logic         lead;
    r    = raw;
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      if (lead && (raw[4*i +: 4] == 4'd0)) r[4*i +: 4] = BLANK_CODE;
      else                                 lead = 1'b0;
    end
    // Minus sits on the first blank digit above the most significant digit
    for (int i = 1; i < int'(DIGITS); i++) begin
      if (minus && (r[4*i +: 4] == BLANK_CODE) && (r[4*(i-1) +: 4] != BLANK_CODE))
        r[4*i +: 4] = MINUS_CODE;
    end
    return r;
  endfunction
`endif

  // Registered output values derived from next-state
  always_comb begin
    logic [W-1:0] raw;
    raw    = '0;
    case (state_d)
      ENTER_A:      raw = a_d;
      ENTER_B, CALC: raw = b_d;
      SHOW:         raw = res_d;
      default:      raw = '0;
    endcase
`ifdef LEADING_BLANK_EN
    disp_d = blank_lead(raw, neg_d);
`else
    disp_d = raw;
`endif
    busy_d = (state_d == CALC);
    done_d = (state_q == CALC) && (state_d == SHOW);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      a_cnt_q  <= '0;
      b_cnt_q  <= '0;
      idx_q    <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      pass2_q  <= 1'b0;
      neg      <= 1'b0;
      overflow <= 1'b0;
      disp     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      a_cnt_q  <= a_cnt_d;
      b_cnt_q  <= b_cnt_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      pass2_q  <= pass2_d;
      neg      <= neg_d;
      overflow <= ovf_d;
      disp     <= disp_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule
